// File: rtl/i2c_init_seq.sv
// ROM-driven I2C initialisation sequencer: walks a 16-bit word program and emits
// I2C master command/data beats, delays, and halts or flags an error.
module i2c_init_seq #(
  parameter int                        ROM_LEN     = 16,
  parameter logic [ROM_LEN-1:0][15:0]  INIT_ROM    = '0,
  parameter int                        DELAY_SHIFT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [6:0] m_axis_cmd_address,
  output logic       m_axis_cmd_start,
  output logic       m_axis_cmd_write,
  output logic       m_axis_cmd_stop,
  output logic       m_axis_cmd_valid,
  input  logic       m_axis_cmd_ready,
  output logic [7:0] m_axis_data_tdata,
  output logic       m_axis_data_tvalid,
  output logic       m_axis_data_tlast,
  input  logic       m_axis_data_tready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(ROM_LEN + 1);
  localparam int CW = 12 + DELAY_SHIFT;

  // state   | meaning
  // IDLE    | waiting for start (also where an error parks)
  // FETCH   | read ROM[index], act on it, index++
  // ISSUE   | command and data beats outstanding
  // DELAY   | counting down a DELAY operand
  // HALT_ST | HALT reached, done held until next start
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DELAY, HALT_ST} state_t;

  state_t          r_state, w_state;
  logic [IW-1:0]   r_index, w_index;
  logic [6:0]      r_addr, w_addr;
  logic            r_first, w_first;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_cmd_valid, w_cmd_valid;
  logic            r_cmd_start, w_cmd_start;
  logic            r_cmd_write, w_cmd_write;
  logic            r_cmd_stop, w_cmd_stop;
  logic            r_data_valid, w_data_valid;
  logic [7:0]      r_tdata, w_tdata;
  logic            r_tlast, w_tlast;
  logic            r_error, w_error;
  logic [15:0]     w_word;
  logic [3:0]      w_op;
  logic [11:0]     w_operand;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < ROM_LEN; i++) begin
      if (r_index == IW'(i)) w_word = INIT_ROM[i];
    end
  end

  assign w_op      = w_word[15:12];
  assign w_operand = w_word[11:0];

  always_comb begin
    w_state      = r_state;
    w_index      = r_index;
    w_addr       = r_addr;
    w_first      = r_first;
    w_cnt        = r_cnt;
    w_cmd_valid  = r_cmd_valid;
    w_cmd_start  = r_cmd_start;
    w_cmd_write  = r_cmd_write;
    w_cmd_stop   = r_cmd_stop;
    w_data_valid = r_data_valid;
    w_tdata      = r_tdata;
    w_tlast      = r_tlast;
    w_error      = r_error;
    case (r_state)
      IDLE, HALT_ST: begin
        if (start) begin
          w_state = FETCH;
          w_index = '0;
          w_first = 1'b1;
          w_error = 1'b0;
        end
      end
      FETCH: begin
        if (r_index == IW'(ROM_LEN)) begin
          // ran off the end of the program without a HALT
          w_error = 1'b1;
          w_state = IDLE;
        end else begin
          w_index = r_index + IW'(1);
          case (w_op)
            4'h0: w_state = HALT_ST;
            4'h1: begin
              w_addr  = w_operand[6:0];
              w_first = 1'b1;
            end
            4'h2, 4'h3: begin
              w_cmd_valid  = 1'b1;
              w_data_valid = 1'b1;
              w_cmd_start  = r_first;
              w_cmd_write  = 1'b1;
              w_cmd_stop   = w_op[0];
              w_tdata      = w_operand[7:0];
              w_tlast      = w_op[0];
              w_first      = w_op[0];
              w_state      = ISSUE;
            end
            4'h4: begin
              if (w_operand != 12'd0) begin
                w_cnt   = (CW'(w_operand) << DELAY_SHIFT) - CW'(1);
                w_state = DELAY;
              end
            end
            default: begin
              w_error = 1'b1;
              w_state = IDLE;
            end
          endcase
        end
      end
      ISSUE: begin
        if (r_cmd_valid && m_axis_cmd_ready) w_cmd_valid = 1'b0;
        if (r_data_valid && m_axis_data_tready) w_data_valid = 1'b0;
        if (!w_cmd_valid && !w_data_valid) w_state = FETCH;
      end
      DELAY: begin
        if (r_cnt == '0) w_state = FETCH;
        else w_cnt = r_cnt - CW'(1);
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_index      <= '0;
      r_addr       <= '0;
      r_first      <= 1'b1;
      r_cnt        <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_start  <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_stop   <= 1'b0;
      r_data_valid <= 1'b0;
      r_tdata      <= '0;
      r_tlast      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_index      <= w_index;
      r_addr       <= w_addr;
      r_first      <= w_first;
      r_cnt        <= w_cnt;
      r_cmd_valid  <= w_cmd_valid;
      r_cmd_start  <= w_cmd_start;
      r_cmd_write  <= w_cmd_write;
      r_cmd_stop   <= w_cmd_stop;
      r_data_valid <= w_data_valid;
      r_tdata      <= w_tdata;
      r_tlast      <= w_tlast;
      r_error      <= w_error;
    end
  end

  assign m_axis_cmd_address = r_addr;
  assign m_axis_cmd_start   = r_cmd_start;
  assign m_axis_cmd_write   = r_cmd_write;
  assign m_axis_cmd_stop    = r_cmd_stop;
  assign m_axis_cmd_valid   = r_cmd_valid;
  assign m_axis_data_tdata  = r_tdata;
  assign m_axis_data_tvalid = r_data_valid;
  assign m_axis_data_tlast  = r_tlast;
  assign busy  = (r_state == FETCH) || (r_state == ISSUE) || (r_state == DELAY);
  assign done  = (r_state == HALT_ST);
  assign error = r_error;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: cycle vector table, hand-written corner cases on small
// programs, and a randomised-backpressure run scored against a program-walk model.
module tb_i2c_init_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // word index 0 is the rightmost entry of each concatenation
  localparam logic [3:0][15:0]  ROM0 = {16'h0000, 16'h3034, 16'h2012, 16'h1050};
  localparam logic [1:0][15:0]  ROM1 = {16'h0000, 16'h4003};
  localparam logic [0:0][15:0]  ROM2 = 16'h7000;
  localparam logic [1:0][15:0]  ROM3 = {16'h2001, 16'h1020};
  localparam logic [15:0][15:0] ROM4 = {{6{16'h0000}}, 16'h0000, 16'h3122, 16'h4002, 16'h1193,
                                        16'h2011, 16'h4000, 16'h30FF, 16'h205A, 16'h20A5, 16'h1042};

  logic st0, cr0, dr0, cs0, cw0, cp0, cv0, dv0, tl0, busy0, done0, err0;
  logic st1, cr1, dr1, cs1, cw1, cp1, cv1, dv1, tl1, busy1, done1, err1;
  logic st2, cr2, dr2, cs2, cw2, cp2, cv2, dv2, tl2, busy2, done2, err2;
  logic st3, cr3, dr3, cs3, cw3, cp3, cv3, dv3, tl3, busy3, done3, err3;
  logic st4, cr4, dr4, cs4, cw4, cp4, cv4, dv4, tl4, busy4, done4, err4;
  logic [6:0] a0, a1, a2, a3, a4;
  logic [7:0] td0, td1, td2, td3, td4;

  i2c_init_seq #(.ROM_LEN(4), .INIT_ROM(ROM0)) u0 (
    .clk(clk), .rst(rst), .start(st0),
    .m_axis_cmd_address(a0), .m_axis_cmd_start(cs0), .m_axis_cmd_write(cw0),
    .m_axis_cmd_stop(cp0), .m_axis_cmd_valid(cv0), .m_axis_cmd_ready(cr0),
    .m_axis_data_tdata(td0), .m_axis_data_tvalid(dv0), .m_axis_data_tlast(tl0),
    .m_axis_data_tready(dr0), .busy(busy0), .done(done0), .error(err0));

  i2c_init_seq #(.ROM_LEN(2), .INIT_ROM(ROM1), .DELAY_SHIFT(2)) u1 (
    .clk(clk), .rst(rst), .start(st1),
    .m_axis_cmd_address(a1), .m_axis_cmd_start(cs1), .m_axis_cmd_write(cw1),
    .m_axis_cmd_stop(cp1), .m_axis_cmd_valid(cv1), .m_axis_cmd_ready(cr1),
    .m_axis_data_tdata(td1), .m_axis_data_tvalid(dv1), .m_axis_data_tlast(tl1),
    .m_axis_data_tready(dr1), .busy(busy1), .done(done1), .error(err1));

  i2c_init_seq #(.ROM_LEN(1), .INIT_ROM(ROM2)) u2 (
    .clk(clk), .rst(rst), .start(st2),
    .m_axis_cmd_address(a2), .m_axis_cmd_start(cs2), .m_axis_cmd_write(cw2),
    .m_axis_cmd_stop(cp2), .m_axis_cmd_valid(cv2), .m_axis_cmd_ready(cr2),
    .m_axis_data_tdata(td2), .m_axis_data_tvalid(dv2), .m_axis_data_tlast(tl2),
    .m_axis_data_tready(dr2), .busy(busy2), .done(done2), .error(err2));

  i2c_init_seq #(.ROM_LEN(2), .INIT_ROM(ROM3)) u3 (
    .clk(clk), .rst(rst), .start(st3),
    .m_axis_cmd_address(a3), .m_axis_cmd_start(cs3), .m_axis_cmd_write(cw3),
    .m_axis_cmd_stop(cp3), .m_axis_cmd_valid(cv3), .m_axis_cmd_ready(cr3),
    .m_axis_data_tdata(td3), .m_axis_data_tvalid(dv3), .m_axis_data_tlast(tl3),
    .m_axis_data_tready(dr3), .busy(busy3), .done(done3), .error(err3));

  i2c_init_seq #(.ROM_LEN(16), .INIT_ROM(ROM4), .DELAY_SHIFT(2)) u4 (
    .clk(clk), .rst(rst), .start(st4),
    .m_axis_cmd_address(a4), .m_axis_cmd_start(cs4), .m_axis_cmd_write(cw4),
    .m_axis_cmd_stop(cp4), .m_axis_cmd_valid(cv4), .m_axis_cmd_ready(cr4),
    .m_axis_data_tdata(td4), .m_axis_data_tvalid(dv4), .m_axis_data_tlast(tl4),
    .m_axis_data_tready(dr4), .busy(busy4), .done(done4), .error(err4));

  // beat monitors, sampled on the active edge (pre-update values)
  int c0 = 0, d0 = 0, c3 = 0, d3 = 0;
  logic [9:0] lc3;
  logic [8:0] ld3;
  logic anyv1 = 1'b0, anyv2 = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      if (cv0 && cr0) c0++;
      if (dv0 && dr0) d0++;
      if (cv3 && cr3) begin c3++; lc3 = {a3, cs3, cw3, cp3}; end
      if (dv3 && dr3) begin d3++; ld3 = {td3, tl3}; end
      if (cv1 || dv1) anyv1 = 1'b1;
      if (cv2 || dv2) anyv2 = 1'b1;
    end
  end

  // scoreboard for u4: expected beats from the program walk, plus hold checks under stall
  logic [9:0] cq[$];
  logic [8:0] dq[$];
  logic       p_cv = 1'b0, p_dv = 1'b0;
  logic [9:0] p_cs;
  logic [8:0] p_ds;
  always @(posedge clk) begin
    if (rst) begin
      p_cv = 1'b0;
      p_dv = 1'b0;
    end else begin
      if (p_cv) chk("cmd_hold", {cv4, a4, cs4, cw4, cp4}, {1'b1, p_cs});
      if (p_dv) chk("data_hold", {dv4, td4, tl4}, {1'b1, p_ds});
      p_cv = cv4 && !cr4;
      p_cs = {a4, cs4, cw4, cp4};
      p_dv = dv4 && !dr4;
      p_ds = {td4, tl4};
      if (cv4 && cr4) begin
        if (cq.size() == 0) chk("cmd_extra_beat", {a4, cs4, cw4, cp4}, 32'hFFFF);
        else chk("cmd_beat", {a4, cs4, cw4, cp4}, cq.pop_front());
      end
      if (dv4 && dr4) begin
        if (dq.size() == 0) chk("data_extra_beat", {td4, tl4}, 32'hFFFF);
        else chk("data_beat", {td4, tl4}, dq.pop_front());
      end
    end
  end

  logic exp_done4, exp_err4;
  task automatic model4();
    logic [6:0]  ad;
    logic        fp;
    logic [15:0] w;
    bit          halted;
    ad = '0; fp = 1'b1; halted = 0;
    exp_err4 = 1'b0;
    for (int i = 0; i < 16 && !halted && !exp_err4; i++) begin
      w = ROM4[i];
      case (w[15:12])
        4'h0: halted = 1;
        4'h1: begin ad = w[6:0]; fp = 1'b1; end
        4'h2, 4'h3: begin
          cq.push_back({ad, fp, 1'b1, w[12]});
          dq.push_back({w[7:0], w[12]});
          fp = w[12];
        end
        4'h4: ;
        default: exp_err4 = 1'b1;
      endcase
    end
    exp_done4 = halted;
    if (!halted) exp_err4 = 1'b1;
  endtask

  function automatic logic [23:0] o0();
    return {busy0, done0, err0, cv0, a0, cs0, cw0, cp0, dv0, td0, tl0};
  endfunction

  function automatic logic [23:0] mk(input logic b, dn, e, cv, input logic [6:0] ad,
                                      input logic s, wr, sp, dv, input logic [7:0] td,
                                      input logic tl);
    return {b, dn, e, cv, ad, s, wr, sp, dv, td, tl};
  endfunction

  typedef struct {
    logic        st;
    logic        cr;
    logic        dr;
    logic [23:0] exp;
  } vec_t;

  vec_t vt[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] m;
    logic        got;
    int          bc, bd, nb;
    bit          fin;

    vt[0] = '{1'b1, 1'b1, 1'b1, mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 0, 8'h00, 0)};
    vt[1] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 0, 8'h00, 0)};
    vt[2] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 1, 7'h50, 1, 1, 0, 1, 8'h12, 0)};
    vt[3] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 0, 8'h00, 0)};
    vt[4] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 1, 7'h50, 0, 1, 1, 1, 8'h34, 1)};
    vt[5] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 7'h00, 0, 0, 0, 0, 8'h00, 0)};
    vt[6] = '{1'b0, 1'b1, 1'b1, mk(0, 1, 0, 0, 7'h00, 0, 0, 0, 0, 8'h00, 0)};
    vt[7] = '{1'b0, 1'b1, 1'b1, mk(0, 1, 0, 0, 7'h00, 0, 0, 0, 0, 8'h00, 0)};

    {st0, cr0, dr0, st1, cr1, dr1, st2, cr2, dr2, st3, cr3, dr3, st4, cr4, dr4} = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", o0(), 24'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_without_start", {busy0, cv0, dv0, done0}, 4'b0000);

    // always-ready cycle table for the two-write program
    for (int i = 0; i < 8; i++) begin
      st0 = vt[i].st; cr0 = vt[i].cr; dr0 = vt[i].dr;
      @(negedge clk);
      m = 24'hFFFFFF;
      if (!vt[i].exp[20]) m &= ~24'h0FFC00;
      if (!vt[i].exp[9])  m &= ~24'h0001FF;
      chk($sformatf("vec%0d", i), o0() & m, vt[i].exp & m);
    end
    chk("vec_beat_counts", {c0[7:0], d0[7:0]}, 16'h0202);

    // command side stalled 10 cycles, data side ready
    bc = c0; bd = d0;
    st0 = 1'b1; cr0 = 1'b0; dr0 = 1'b1; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      st0 = 1'b0;
      if (cv0) got = 1'b1;
    end
    chk("stall_reach_valid", got, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_cmd_hold", {cv0, a0, cs0, cw0, cp0}, {1'b1, 7'h50, 1'b1, 1'b1, 1'b0});
    end
    chk("stall_data_once", d0 - bd, 1);
    chk("stall_no_cmd_beat", c0 - bc, 0);
    chk("stall_data_dropped", dv0, 0);
    cr0 = 1'b1;
    for (int k = 0; k < 20 && !done0; k++) @(negedge clk);
    chk("stall_done", done0, 1);
    chk("stall_beats", {8'(c0 - bc), 8'(d0 - bd)}, 16'h0202);

    // DELAY 3 with 2^2-cycle units
    st1 = 1'b1; cr1 = 1'b1; dr1 = 1'b1; nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      st1 = 1'b0;
      if (done1) break;
      if (busy1) nb++;
    end
    chk("delay_busy_cycles", nb, 14);
    chk("delay_done", {done1, err1, anyv1}, 3'b100);

    // illegal opcode, then restart clears error
    st2 = 1'b1; cr2 = 1'b1; dr2 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      st2 = 1'b0;
      if (err2) break;
    end
    chk("illegal_error", {err2, busy2, done2, anyv2}, 4'b1000);
    st2 = 1'b1;
    @(negedge clk);
    st2 = 1'b0;
    chk("illegal_restart_clears", {err2, busy2}, 2'b01);
    for (int k = 0; k < 10 && !err2; k++) @(negedge clk);
    chk("illegal_error_again", {err2, busy2, anyv2}, 3'b100);

    // program overrun without HALT
    st3 = 1'b1; cr3 = 1'b1; dr3 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      st3 = 1'b0;
      if (err3) break;
    end
    chk("overrun_error", {err3, done3, busy3}, 3'b100);
    chk("overrun_beats", {c3[7:0], d3[7:0]}, 16'h0101);
    chk("overrun_cmd", lc3, {7'h20, 1'b1, 1'b1, 1'b0});
    chk("overrun_data", ld3, {8'h01, 1'b0});

    // reset while both beats are pending
    st0 = 1'b1; cr0 = 1'b0; dr0 = 1'b0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      st0 = 1'b0;
      if (cv0 && dv0) got = 1'b1;
    end
    chk("rst_reach_valid", got, 1);
    bc = c0; bd = d0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_issue", o0(), 24'h0);
    @(negedge clk);
    rst = 1'b0; cr0 = 1'b1; dr0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_beat", (c0 - bc) + (d0 - bd), 0);
    chk("rst_stays_idle", o0(), 24'h0);

    // randomised backpressure against the program-walk model; run 1 re-pulses start mid-run
    for (int r = 0; r < 3; r++) begin
      model4();
      st4 = 1'b1; fin = 0;
      for (int k = 0; k < 600; k++) begin
        @(negedge clk);
        st4 = (r == 1 && k == 10);
        cr4 = ($urandom_range(0, 99) < 70 - 20 * r);
        dr4 = ($urandom_range(0, 99) < 70 - 20 * r);
        if (done4 || err4) begin fin = 1; break; end
      end
      chk($sformatf("rand_end_run%0d", r), {fin, done4, err4}, {1'b1, exp_done4, exp_err4});
      chk($sformatf("rand_cmd_left_run%0d", r), cq.size(), 0);
      chk($sformatf("rand_data_left_run%0d", r), dq.size(), 0);
      cq.delete(); dq.delete();
      cr4 = 1'b0; dr4 = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
